// File: rtl/cac_pkg.sv
// Shared register map, control-field positions and page-index width for the event monitor.
package cac_pkg;

  localparam int ADDR_STICKY   = 'h00;
  localparam int ADDR_LIVE     = 'h01;
  localparam int ADDR_CTRL     = 'h02;
  localparam int ADDR_MASK     = 'h03;
  localparam int ADDR_CNT_BASE = 'h10;

  localparam int CTRL_FREEZE   = 0;
  localparam int CTRL_SCROLL   = 1;
  localparam int CTRL_PAGE_LSB = 2;

  // Pages run 0..num_ch, so the index needs room for num_ch+1 values.
  function automatic int page_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/cac_event_counter.sv
// One monitored channel: rising-edge detect plus a saturating event counter.
// A clear that coincides with an unfrozen edge leaves the count at 1.
module cac_event_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ev_i,
  input  logic                 freeze_i,
  input  logic                 clr_i,
  output logic                 edge_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic                 ev_prev_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 bump;

  assign edge_o = ev_i & ~ev_prev_q;
  assign bump   = edge_o & ~freeze_i;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = bump ? CNT_WIDTH'(1) : '0;
    end else if (bump && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ev_prev_q <= ev_i;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/cac_event_monitor.sv
// Event monitor: sticky edge flags, per-channel counters, register file, irq and paged debug LEDs.
// All outputs are registered; register reads return state from before a same-cycle write.
module cac_event_monitor
  import cac_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LED_WIDTH  = 16,
  parameter int SCROLL_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ev_in,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  irq,
  output logic [LED_WIDTH-1:0]  debug_leds
);

  localparam int PW     = page_width(NUM_CH);
  localparam int CTRL_W = CTRL_PAGE_LSB + PW;
  localparam int DIV_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  int                    addr_int;
  logic [NUM_CH-1:0]     ev_edge;
  logic [NUM_CH-1:0]     cnt_clr;
  logic [CNT_WIDTH-1:0]  cnt [NUM_CH];

  logic [NUM_CH-1:0]     sticky_q, sticky_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [PW-1:0]         scroll_pg_q, scroll_pg_d;
  logic [PW-1:0]         page_sel;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q;
  logic [LED_WIDTH-1:0]  leds_q, leds_d;
  logic                  unused_wdata;

  assign addr_int     = int'(addr);
  assign unused_wdata = ^wdata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cnt_clr[i] = wen && (addr_int == ADDR_CNT_BASE + i);
    cac_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .ev_i     (ev_in[i]),
      .freeze_i (ctrl_q[CTRL_FREEZE]),
      .clr_i    (cnt_clr[i]),
      .edge_o   (ev_edge[i]),
      .cnt_o    (cnt[i])
    );
  end

  always_comb begin
    sticky_d = sticky_q;
    if (wen && addr_int == ADDR_STICKY) sticky_d = sticky_q & ~wdata[NUM_CH-1:0];
    // A new edge wins over a clear of the same bit.
    sticky_d = sticky_d | ev_edge;
    mask_d   = (wen && addr_int == ADDR_MASK) ? wdata[NUM_CH-1:0] : mask_q;
    ctrl_d   = (wen && addr_int == ADDR_CTRL) ? wdata[CTRL_W-1:0] : ctrl_q;
  end

  always_comb begin
    div_d       = div_q;
    scroll_pg_d = scroll_pg_q;
    if (ctrl_d[CTRL_SCROLL] && !ctrl_q[CTRL_SCROLL]) begin
      div_d       = '0;
      scroll_pg_d = '0;
    end else if (ctrl_q[CTRL_SCROLL]) begin
      if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
        div_d       = '0;
        scroll_pg_d = (scroll_pg_q == PW'(NUM_CH)) ? '0 : scroll_pg_q + PW'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (addr_int == ADDR_STICKY) rdata_d = DATA_WIDTH'(sticky_q);
    if (addr_int == ADDR_LIVE)   rdata_d = DATA_WIDTH'(ev_in);
    if (addr_int == ADDR_CTRL)   rdata_d = DATA_WIDTH'(ctrl_q);
    if (addr_int == ADDR_MASK)   rdata_d = DATA_WIDTH'(mask_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_int == ADDR_CNT_BASE + i) rdata_d = DATA_WIDTH'(cnt[i]);
    end
  end

  assign page_sel = ctrl_q[CTRL_SCROLL] ? scroll_pg_q : ctrl_q[CTRL_PAGE_LSB +: PW];

  always_comb begin
    leds_d = '0;
    if (page_sel == '0) leds_d = LED_WIDTH'(sticky_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (page_sel == PW'(i + 1)) leds_d = LED_WIDTH'(cnt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q    <= '0;
      mask_q      <= '0;
      ctrl_q      <= '0;
      div_q       <= '0;
      scroll_pg_q <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      leds_q      <= '0;
    end else begin
      sticky_q    <= sticky_d;
      mask_q      <= mask_d;
      ctrl_q      <= ctrl_d;
      div_q       <= div_d;
      scroll_pg_q <= scroll_pg_d;
      rdata_q     <= rdata_d;
      irq_q       <= |(sticky_q & mask_q);
      leds_q      <= leds_d;
    end
  end

  assign rdata      = rdata_q;
  assign irq        = irq_q;
  assign debug_leds = leds_q;

endmodule

// File: doc/cac_event_monitor.md
CAC_EVENT_MONITOR -- requirements
Module: cac_event_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of monitored event channels, 1..DATA_WIDTH.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: per-channel event counter width, at most DATA_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: register data width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8: register address width.
REQ-005 SHALL have parameter LED_WIDTH, default 16: debug LED bus width.
REQ-006 SHALL have parameter SCROLL_DIV, default 100_000_000: clock cycles per auto-scroll page.
REQ-007 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port ev_in, input, NUM_CH: level status inputs, already synchronous to clk.
REQ-010 SHALL have port wen, input, 1: register write strobe.
REQ-011 SHALL have port addr, input, ADDR_WIDTH: register address.
REQ-012 SHALL have port wdata, input, DATA_WIDTH: write data.
REQ-013 SHALL have port rdata, output, DATA_WIDTH: registered read data.
REQ-014 SHALL have port irq, output, 1: OR of (sticky AND mask), registered.
REQ-015 SHALL have port debug_leds, output, LED_WIDTH: selected page, registered.

Function
REQ-016 SHALL detect a rising edge on ev_in[i] as ev_in[i]=1 with previous-cycle sample 0; the previous sample resets to 0.
REQ-017 SHALL set sticky[i] on every edge; sticky bits clear only by write-1-to-clear at 0x00.
REQ-018 SHALL give edge set priority over W1C clear of the same bit in the same cycle.
REQ-019 SHALL increment cnt[i] by 1 per edge, saturating at all-ones, unless ctrl.freeze=1.
REQ-020 SHALL clear cnt[i] on any write to 0x10+i; a simultaneous unfrozen edge SHALL leave cnt[i]=1.
REQ-021 SHALL use this map: 0x00 sticky, W1C; 0x01 live ev_in, RO; 0x02 ctrl, RW; 0x03 irq mask, RW; 0x10..0x10+NUM_CH-1 counters, read returns value, write clears.
REQ-022 SHALL use ctrl bit0 = freeze, bit1 = auto_scroll, and bits[2 +: PW] = manual page, where PW = clog2(NUM_CH+1).
REQ-023 SHALL present rdata one cycle after addr; it SHALL hold until the next address.
REQ-024 SHALL zero-extend narrower fields in rdata; unmapped addresses read 0.
REQ-025 SHALL ignore writes to read-only or unmapped addresses.
REQ-026 SHALL show read data that reflects state before a same-cycle write.
REQ-027 SHALL drive irq one cycle after the sticky or mask change that causes it.
REQ-028 SHALL drive page 0 on debug_leds as sticky flags and page k (1..NUM_CH) as cnt[k-1], zero-extended or truncated to LED_WIDTH; page >NUM_CH shows 0.
REQ-029 SHALL, when auto_scroll=1, run a divider 0..SCROLL_DIV-1; at terminal count the page SHALL advance modulo NUM_CH+1.
REQ-030 SHALL, when auto_scroll=0, use the manual page; the divider and scroll index SHALL hold.
REQ-031 SHALL, when auto_scroll rises, restart the scroll from page 0 with divider 0.

Reset
REQ-032 SHALL, on rst=1 at a clk edge, zero sticky, counters, ctrl, mask, edge samples, divider, scroll index, rdata, irq and debug_leds.
REQ-033 SHALL have rst override wen and edges in the same cycle; a rst mid-scroll returns debug_leds to page 0 next cycle.

Structure
REQ-034 SHALL place register address constants, ctrl bit positions and the PW width function in shared package cac_pkg.
REQ-035 SHALL instantiate NUM_CH copies of sub-module cac_event_counter; each holds edge detect, saturating counter and clear/freeze logic.
REQ-036 SHALL keep sticky, mask, ctrl, read mux, irq and LED paging in cac_event_monitor.

Verification
REQ-037 SHALL test: pulse ev_in[3] 5 times -> read 0x13 = 5, 0x00 = 0x0008; write 0x00 = 0x0008 -> read 0x00 = 0.
REQ-038 SHALL test: CNT_WIDTH=4, 20 edges on ch0 -> 0x10 reads 15; write 0x10 in the same cycle as an edge -> reads 1.
REQ-039 SHALL test: ctrl=0x0001 plus 3 edges on ch1 -> cnt unchanged, sticky[1]=1; mask=0x0002 -> irq=1 one cycle later.
REQ-040 SHALL test: W1C of bit 2 in the same cycle as an edge on ch2 -> sticky[2] stays 1.
REQ-041 SHALL test: SCROLL_DIV=4, NUM_CH=2, ctrl=0x0002 -> page advances every 4 cycles, order 0,1,2,0.
REQ-042 SHALL test: rst asserted mid-scroll with cnt=7 -> all outputs 0 next cycle; reads of 0x00..0x11 return 0.
